// File: rtl/clkdiv_seq_ctrl.sv
// Sequencer that owns n/enable/reset of the divide-by-N clock generator and reprograms it glitch-safely.
// Optional feature macro: CLKDIV_SEQ_TIMEOUT_EN bounds the DRAIN wait to TIMEOUT_CYCLES and flags a timeout.
module clkdiv_seq_ctrl #(
  parameter logic [7:0]  DEFAULT_N      = 8'd2,
  parameter int unsigned GATE_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_n,
  output logic       req_ready,
  input  logic       div_clk_in,
  output logic [7:0] div_n,
  output logic       div_enable,
  output logic       div_reset,
  output logic [7:0] cur_n,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRAIN,
    S_GATE,
    S_LOAD,
    S_SETTLE
  } state_e;

  localparam logic [15:0] GATE_LEN    = 16'(GATE_CYCLES);
  localparam logic [15:0] SETTLE_LEN  = 16'(SETTLE_CYCLES);
  localparam logic [15:0] TIMEOUT_LEN = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pend_n_q, pend_n_d;
  logic [7:0]  div_n_q, div_n_d;
  logic [7:0]  cur_n_q, cur_n_d;
  logic        div_enable_q, div_enable_d;
  logic        div_reset_q, div_reset_d;
  logic        busy_q, busy_d;
  logic        req_ready_q, req_ready_d;
  logic        done_q, done_d;
  logic        init_q, init_d;
  logic        sync1_q, fb_s_q;
`ifdef CLKDIV_SEQ_TIMEOUT_EN
  logic        timeout_q, timeout_d;
`endif

  // div_clk_in is asynchronous to clk; only the second stage is ever used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      fb_s_q  <= 1'b0;
    end else begin
      sync1_q <= div_clk_in;
      fb_s_q  <= sync1_q;
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_n_d     = pend_n_q;
    div_n_d      = div_n_q;
    cur_n_d      = cur_n_q;
    div_enable_d = div_enable_q;
    div_reset_d  = div_reset_q;
    busy_d       = busy_q;
    req_ready_d  = req_ready_q;
    done_d       = 1'b0;
    init_d       = init_q;
`ifdef CLKDIV_SEQ_TIMEOUT_EN
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      // INIT counts up from the reset value of cnt; every other state counts down from its entry load.
      S_INIT: begin
        div_enable_d = 1'b0;
        div_reset_d  = 1'b1;
        if (cnt_q == GATE_LEN - 16'd1) begin
          state_d      = S_SETTLE;
          cnt_d        = SETTLE_LEN;
          div_reset_d  = 1'b0;
          div_enable_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_IDLE: begin
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          pend_n_d    = req_n;
          req_ready_d = 1'b0;
          if (req_n == cur_n_q) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            if (cur_n_q < 8'd2) begin
              // Bypass has no divided phase to wait for.
              state_d      = S_GATE;
              cnt_d        = GATE_LEN;
              div_enable_d = 1'b0;
              div_reset_d  = 1'b1;
            end else begin
              state_d = S_DRAIN;
              cnt_d   = TIMEOUT_LEN;
            end
          end
        end
      end

      S_DRAIN: begin
        if (!fb_s_q) begin
          state_d      = S_GATE;
          cnt_d        = GATE_LEN;
          div_enable_d = 1'b0;
          div_reset_d  = 1'b1;
        end
`ifdef CLKDIV_SEQ_TIMEOUT_EN
        else if (cnt_q == 16'd1) begin
          state_d      = S_GATE;
          cnt_d        = GATE_LEN;
          div_enable_d = 1'b0;
          div_reset_d  = 1'b1;
          timeout_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
`endif
      end

      S_GATE: begin
        if (cnt_q == 16'd1) begin
          // New ratio appears at the divider while it is still held in reset.
          state_d = S_LOAD;
          div_n_d = pend_n_q;
          cur_n_d = pend_n_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_LOAD: begin
        state_d      = S_SETTLE;
        cnt_d        = SETTLE_LEN;
        div_reset_d  = 1'b0;
        div_enable_d = 1'b1;
      end

      S_SETTLE: begin
        if (cnt_q == 16'd1) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
          done_d      = !init_q;
          init_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      cnt_q        <= 16'd0;
      pend_n_q     <= DEFAULT_N;
      div_n_q      <= DEFAULT_N;
      cur_n_q      <= DEFAULT_N;
      div_enable_q <= 1'b0;
      div_reset_q  <= 1'b1;
      busy_q       <= 1'b1;
      req_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      init_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_n_q     <= pend_n_d;
      div_n_q      <= div_n_d;
      cur_n_q      <= cur_n_d;
      div_enable_q <= div_enable_d;
      div_reset_q  <= div_reset_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
      done_q       <= done_d;
      init_q       <= init_d;
    end
  end

`ifdef CLKDIV_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign req_ready  = req_ready_q;
  assign div_n      = div_n_q;
  assign div_enable = div_enable_q;
  assign div_reset  = div_reset_q;
  assign cur_n      = cur_n_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Scoreboard bench for clkdiv_seq_ctrl with a behavioural divide-by-N model closing the feedback loop.
// Build with CLKDIV_SEQ_TIMEOUT_EN defined to also exercise the DRAIN timeout.
module tb_clkdiv_seq_ctrl;

  localparam int GATE   = 4;
  localparam int SETTLE = 16;
  localparam int TMO    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_n = 8'd0;
  logic       req_ready, div_clk_in, div_enable, div_reset, busy, done, timeout;
  logic [7:0] div_n, cur_n;

  clkdiv_seq_ctrl #(
    .DEFAULT_N(8'd2), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .div_clk_in(div_clk_in), .div_n(div_n), .div_enable(div_enable), .div_reset(div_reset),
    .cur_n(cur_n), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_cur = 8'd2;

  // Behavioural divider: high for n/2 of every n cycles, idle at 0 in reset or bypass.
  logic       force_hi = 1'b0;
  logic       mdl_out = 1'b0;
  logic [7:0] mdl_cnt = 8'd0;
  assign div_clk_in = force_hi | mdl_out;

  always @(posedge clk) begin
    logic [7:0] nxt;
    if (div_reset) begin
      mdl_cnt <= 8'd0;
      mdl_out <= 1'b0;
    end else if (div_enable && div_n >= 8'd2) begin
      nxt = (mdl_cnt >= div_n - 8'd1) ? 8'd0 : mdl_cnt + 8'd1;
      mdl_cnt <= nxt;
      mdl_out <= (nxt < (div_n >> 1));
    end else begin
      mdl_out <= 1'b0;
    end
  end

  // Safety monitors, summarised by checks at the end.
  logic       overlap_seen = 1'b0;
  logic       divn_glitch = 1'b0;
  logic [7:0] prev_div_n = 8'd2;
  always @(negedge clk) begin
    if (div_enable && div_reset) overlap_seen = 1'b1;
    if (div_n !== prev_div_n && !div_reset) divn_glitch = 1'b1;
    prev_div_n = div_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {div_n, cur_n, div_enable, div_reset, busy, req_ready, done, timeout},
          {8'd2, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  // Called at a negedge with reset high; releases reset and measures the bring-up sequence.
  task automatic bring_up(input string tag);
    int cyc, rst_cnt, en_cnt, done_cnt;
    reset    = 1'b0;
    cyc      = 1;
    rst_cnt  = int'(div_reset);
    en_cnt   = int'(div_enable);
    done_cnt = int'(done);
    while (!req_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
      done_cnt += int'(done);
      if (!req_ready) begin
        rst_cnt += int'(div_reset);
        en_cnt  += int'(div_enable);
      end
    end
    check({tag, "_ready_cycle"}, cyc, 21);
    check({tag, "_reset_cycles"}, rst_cnt, GATE);
    check({tag, "_enable_cycles"}, en_cnt, SETTLE);
    check({tag, "_no_done"}, done_cnt, 0);
    check({tag, "_n"}, {div_n, cur_n, busy}, {8'd2, 8'd2, 1'b0});
    model_cur = 8'd2;
  endtask

  // Issues one request, then waits for done and scores it against the queue.
  task automatic do_request(input logic [7:0] n, input int force_cycles, input bit hold_force);
    exp_t e;
    int   lat, waitc;
    if (force_cycles > 0) begin
      force_hi = 1'b1;
      repeat (3) @(negedge clk);
    end
    waitc = 0;
    while (!req_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_wait", waitc < 200, 1);
    e.n = n;
    if (n == model_cur)    e.lat = 1;
    else if (model_cur < 2) e.lat = GATE + 1 + SETTLE + 1;
    else if (hold_force)   e.lat = TMO + GATE + 1 + SETTLE + 1;
    else                   e.lat = -1;
    sb_q.push_back(e);
    req_valid = 1'b1;
    req_n     = n;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      if (force_cycles > 0 && !hold_force && lat == force_cycles) begin
        check("drain_hold", {busy, div_enable, div_reset}, 3'b110);
        force_hi = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    force_hi = 1'b0;
    check("done_seen", done, 1);
    if (done) begin
      check("sb_size", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("done_cur_n", cur_n, e.n);
        check("done_div_n", div_n, e.n);
        if (e.lat >= 0) check("latency", lat, e.lat);
        else            check("latency_min", lat >= GATE + SETTLE + 3, 1);
        check("ready_at_done", req_ready, e.lat != 1);
        model_cur = e.n;
      end
    end
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   rises, waitc;
    logic prev;
    exp_t e;

    repeat (3) @(negedge clk);
    check_reset_vals("reset_vals");
    bring_up("boot");

    // 2 -> 5 through a DRAIN held off by forced-high feedback.
    do_request(8'd5, 6, 1'b0);
    rises = 0;
    prev  = div_clk_in;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (div_clk_in && !prev) rises++;
      prev = div_clk_in;
    end
    check("div_by_5_rises", rises, 20);

    // 5 -> 1 (bypass), then 1 -> 6 skips DRAIN with exact latency.
    do_request(8'd1, 0, 1'b0);
    do_request(8'd6, 0, 1'b0);

    // Same divisor: immediate done, divider left running.
    do_request(8'd6, 0, 1'b0);
    check("equal_outputs", {div_enable, div_reset, busy, cur_n}, {1'b1, 1'b0, 1'b0, 8'd6});

`ifdef CLKDIV_SEQ_TIMEOUT_EN
    check("timeout_clear", timeout, 0);
    do_request(8'd4, 1, 1'b1);
    check("timeout_set", timeout, 1);
    do_request(8'd7, 0, 1'b0);
    check("timeout_sticky", timeout, 1);
`else
    check("timeout_tied", timeout, 0);
`endif

    // 6 -> 2, then 2 -> 9 interrupted by reset during SETTLE.
    do_request(8'd2, 0, 1'b0);
    waitc = 0;
    while (!req_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    e.n = 8'd9;
    e.lat = -1;
    sb_q.push_back(e);
    req_valid = 1'b1;
    req_n     = 8'd9;
    @(negedge clk);
    req_valid = 1'b0;
    waitc = 0;
    while (!(div_n == 8'd9 && !div_reset) && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    check("reached_settle", waitc < 2000, 1);
    repeat (3) @(negedge clk);
    check("settle_busy", {busy, div_enable, div_reset}, 3'b110);
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset_vals");
    sb_q.delete();
    @(negedge clk);
    bring_up("reboot");

    // Normal operation resumes from the default divisor.
    do_request(8'd3, 0, 1'b0);

    check("no_enable_reset_overlap", overlap_seen, 0);
    check("div_n_only_in_reset", divn_glitch, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
